uart_tx_frame: RTL and testbench

Transmit framing engine for the APB UART transmitter path. Accepts a byte on a start strobe, latches it, presents the latched byte to the parity generator and consumes the returned parity bit, then serialises start bit, 8 data bits LSB-first, optional parity bit and 1 or 2 stop bits onto the serial line. It sits between the TX holding register/FIFO (upstream) and the `tx` pad (downstream), with the parity generator as a side stage.

---
 rtl/uart_tx_frame.sv | 136 +++++++++++++
 tb/tb_uart_tx_frame.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framing engine: latches a byte on start, then serialises
// start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_tx_frame #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_start_i,
  input  logic [7:0]       data_i,
  input  logic             parity_en_i,
  input  logic             parity_type_i,
  input  logic             stop_bits_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             parity_bit_i,
  output logic [7:0]       data_o,
  output logic             parity_type_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] baud_nxt;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_nxt;
  logic [DIV_W-1:0] div_sh;
  logic             par_en_sh;
  logic             stop2_sh;
  logic             tick;
  logic             accept;
  logic             tx_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // Parity selection goes straight to the external parity generator.
  assign parity_type_o = parity_type_i;

  assign tick   = (baud_cnt == div_sh);
  assign accept = (state == IDLE) && tx_start_i;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and counter sequencing; bit_cnt also counts stop periods.
  always_comb begin
    state_nxt = state;
    baud_nxt  = tick ? '0 : baud_cnt + DIV_W'(1);
    bit_nxt   = bit_cnt;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        if (tx_start_i) state_nxt = START;
      end
      START: begin
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        if (tick) begin
          bit_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = par_en_sh ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick) state_nxt = STOP;
      end
      STOP: begin
        if (tick) begin
          bit_nxt = bit_cnt + 3'd1;
          if (!stop2_sh || bit_cnt[0]) begin
            state_nxt = IDLE;
            bit_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle, registered below so tx never glitches.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == STOP) && (state_nxt == IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_o[bit_nxt];
      PARITY:  tx_nxt = parity_bit_i;
      default: tx_nxt = 1'b1;
    endcase
  end

  // Frame datapath: shadowed configuration, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      div_sh    <= '0;
      par_en_sh <= 1'b0;
      stop2_sh  <= 1'b0;
      data_o    <= 8'h00;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx_o     <= tx_nxt;
      busy_o   <= busy_nxt;
      done_o   <= done_nxt;
      if (accept) begin
        data_o    <= data_i;
        div_sh    <= baud_div_i;
        par_en_sh <= parity_en_i;
        stop2_sh  <= stop_bits_i;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with a behavioural parity generator.
module tb_uart_tx_frame;

  localparam int unsigned DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             tx_start_i;
  logic [7:0]       data_i;
  logic             parity_en_i;
  logic             parity_type_i;
  logic             stop_bits_i;
  logic [DIV_W-1:0] baud_div_i;
  logic             parity_bit_i;
  logic [7:0]       data_o;
  logic             parity_type_o;
  logic             tx_o;
  logic             busy_o;
  logic             done_o;

  int checks   = 0;
  int failures = 0;

  uart_tx_frame #(.DIV_W(DIV_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_start_i    (tx_start_i),
    .data_i        (data_i),
    .parity_en_i   (parity_en_i),
    .parity_type_i (parity_type_i),
    .stop_bits_i   (stop_bits_i),
    .baud_div_i    (baud_div_i),
    .parity_bit_i  (parity_bit_i),
    .data_o        (data_o),
    .parity_type_o (parity_type_o),
    .tx_o          (tx_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  // Parity generator: type 1 returns XOR of the byte, type 0 its complement.
  assign parity_bit_i = parity_type_o ? (^data_o) : ~(^data_o);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called one cycle after the accepting edge; returns in the done_o cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, input bit pen,
                           input bit pbit, input bit s2, input int div, input bit mutate);
    logic bits [12];
    int   nbits;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nbits = 9;
    if (pen) begin
      bits[nbits] = pbit;
      nbits++;
    end
    bits[nbits] = 1'b1;
    nbits++;
    if (s2) begin
      bits[nbits] = 1'b1;
      nbits++;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c <= div; c++) begin
        if (mutate && b == 3 && c == 0) begin
          data_i      = 8'h00;
          baud_div_i  = 16'd0;
          parity_en_i = 1'b1;
          stop_bits_i = 1'b1;
          tx_start_i  = 1'b1;
        end
        if (mutate && b == 3 && c == 1) tx_start_i = 1'b0;
        chk($sformatf("%s_tx_b%0d_c%0d", tag, b, c), 32'(tx_o), 32'(bits[b]));
        chk($sformatf("%s_busy_b%0d_c%0d", tag, b, c), 32'(busy_o), 32'd1);
        chk($sformatf("%s_done_b%0d_c%0d", tag, b, c), 32'(done_o), 32'd0);
        step();
      end
    end
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd1);
    chk({tag, "_end_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_end_tx"}, 32'(tx_o), 32'd1);
  endtask

  task automatic start_frame(input logic [7:0] d, input bit pen, input bit ptype,
                             input bit s2, input logic [DIV_W-1:0] div);
    data_i        = d;
    parity_en_i   = pen;
    parity_type_i = ptype;
    stop_bits_i   = s2;
    baud_div_i    = div;
    tx_start_i    = 1'b1;
    step();
    tx_start_i    = 1'b0;
  endtask

  task automatic idle_after(input string tag);
    step();
    chk({tag, "_post_done"}, 32'(done_o), 32'd0);
    chk({tag, "_post_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_post_tx"}, 32'(tx_o), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    tx_start_i    = 1'b0;
    data_i        = 8'h00;
    parity_en_i   = 1'b0;
    parity_type_i = 1'b0;
    stop_bits_i   = 1'b0;
    baud_div_i    = 16'd0;
    #12;
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'h00);
    reset = 1'b0;
    step();
    step();
    chk("idle_tx", 32'(tx_o), 32'd1);
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Basic frame, div=3, 8'hA5, no parity, one stop bit.
    start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 16'd3);
    run_frame("basic", 8'hA5, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    chk("basic_data_hold", 32'(data_o), 32'hA5);
    idle_after("basic");
    chk("basic_data_idle", 32'(data_o), 32'hA5);

    // Parity, div=0, 8'h07: type 1 gives parity 1, type 0 gives parity 0.
    start_frame(8'h07, 1'b1, 1'b1, 1'b0, 16'd0);
    run_frame("par1", 8'h07, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    idle_after("par1");
    start_frame(8'h07, 1'b1, 1'b0, 1'b0, 16'd0);
    run_frame("par0", 8'h07, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle_after("par0");

    // Two stop bits, div=1, 8'hFF.
    start_frame(8'hFF, 1'b0, 1'b0, 1'b1, 16'd1);
    run_frame("stop2", 8'hFF, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    idle_after("stop2");

    // Back-to-back with tx_start_i held high.
    data_i      = 8'h12;
    parity_en_i = 1'b0;
    stop_bits_i = 1'b0;
    baud_div_i  = 16'd1;
    tx_start_i  = 1'b1;
    step();
    data_i = 8'h34;
    run_frame("b2b_first", 8'h12, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    step();
    tx_start_i = 1'b0;
    chk("b2b_data_latched", 32'(data_o), 32'h34);
    run_frame("b2b_second", 8'h34, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    idle_after("b2b");

    // Mid-frame config changes and a start pulse while busy are ignored.
    start_frame(8'hC3, 1'b0, 1'b0, 1'b0, 16'd3);
    run_frame("mid", 8'hC3, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    idle_after("mid");
    step();
    chk("mid_no_second_busy", 32'(busy_o), 32'd0);
    chk("mid_no_second_tx", 32'(tx_o), 32'd1);
    chk("mid_data_kept", 32'(data_o), 32'hC3);

    // Reset during data bit 3 aborts the frame without a clock edge.
    start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 16'd3);
    for (int i = 0; i < 17; i++) step();
    chk("abort_pre_tx", 32'(tx_o), 32'd0);
    chk("abort_pre_busy", 32'(busy_o), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_tx", 32'(tx_o), 32'd1);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_data", 32'(data_o), 32'h00);
    step();
    #2;
    reset = 1'b0;
    step();
    chk("abort_idle_tx", 32'(tx_o), 32'd1);
    start_frame(8'h55, 1'b0, 1'b0, 1'b0, 16'd1);
    run_frame("after_rst", 8'h55, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    idle_after("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
